// File: rtl/mqnic_l2_pkg.sv
// Shared constants, state encoding and PAUSE frame byte map for the mqnic L2 egress MAC control block.
package mqnic_l2_pkg;

    localparam logic [47:0] MAC_CTRL_DA        = 48'h01_80_C2_00_00_01;
    localparam logic [15:0] MAC_CTRL_ETHERTYPE = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE       = 16'h0001;
    localparam int          PAUSE_FRAME_BYTES  = 60;

    // Wide enough for the 8-beat frame produced by a 64-bit stream.
    localparam int BEAT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA     = 2'd1,
        PAUSE_TX = 2'd2
    } egress_state_t;

    function automatic int pause_beats(input int keep_width);
        return (PAUSE_FRAME_BYTES + keep_width - 1) / keep_width;
    endfunction

    // Byte idx of the FCS-less PAUSE frame; multi-byte fields go out MSB first.
    function automatic logic [7:0] pause_byte(input int idx, input logic [15:0] quanta,
                                              input logic [47:0] mac);
        logic [7:0] b;
        b = 8'h00;
        if (idx < 6)
            b = MAC_CTRL_DA[8*(5-idx) +: 8];
        else if (idx < 12)
            b = mac[8*(11-idx) +: 8];
        else if (idx < 14)
            b = MAC_CTRL_ETHERTYPE[8*(13-idx) +: 8];
        else if (idx < 16)
            b = PAUSE_OPCODE[8*(15-idx) +: 8];
        else if (idx < 18)
            b = quanta[8*(17-idx) +: 8];
        return b;
    endfunction

endpackage

// File: rtl/mqnic_l2_egress_mac_ctrl_pause_gen.sv
// mqnic_pause_frame_gen: combinational beat generator for a 60-byte IEEE 802.3x PAUSE frame.
module mqnic_pause_frame_gen
    import mqnic_l2_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8
) (
    input  logic [BEAT_W-1:0]          beat,
    input  logic [15:0]                quanta,
    input  logic [47:0]                mac,
    output logic [AXIS_DATA_WIDTH-1:0] tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] tkeep,
    output logic                       tlast
);

    localparam int BEATS = pause_beats(AXIS_KEEP_WIDTH);

    always_comb begin
        tdata = '0;
        tkeep = '0;
        for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
            tdata[8*i +: 8] = pause_byte(int'(beat)*AXIS_KEEP_WIDTH + i, quanta, mac);
            tkeep[i]        = (int'(beat)*AXIS_KEEP_WIDTH + i) < PAUSE_FRAME_BYTES;
        end
        tlast = (int'(beat) == BEATS - 1);
    end

endmodule

// File: rtl/mqnic_l2_egress_mac_ctrl.sv
// L2 egress MAC control: data passthrough, PAUSE frame insertion at frame boundaries, rx-pause hold-off.
// Optional statistics counters are enabled with `define MQNIC_L2_EGRESS_STATS_EN.
module mqnic_l2_egress_mac_ctrl
    import mqnic_l2_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH      = 256,
    parameter int AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH/8,
    parameter int AXIS_USER_WIDTH      = 1,
    parameter int AXIS_USE_READY       = 0,
    parameter int PAUSE_QUANTUM_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,

    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,

    input  logic                       tx_pause_req,
    input  logic [15:0]                tx_pause_quanta,
    input  logic [47:0]                cfg_local_mac,
    input  logic                       rx_pause_valid,
    input  logic [15:0]                rx_pause_quanta,
    output logic                       tx_paused
`ifdef MQNIC_L2_EGRESS_STATS_EN
    ,
    output logic [31:0]                stat_pause_tx_frames,
    output logic [31:0]                stat_paused_cycles
`endif
);

    localparam int TIMER_W = 16 + $clog2(PAUSE_QUANTUM_CYCLES + 1);
    localparam int PAUSE_BEATS = pause_beats(AXIS_KEEP_WIDTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAUSE_BEATS - 1);

    egress_state_t        state;
    logic                 pending;
    logic [15:0]          req_quanta;
    logic [15:0]          frame_quanta;
    logic [BEAT_W-1:0]    beat;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_next;
    logic                 tready_eff;
    logic                 accept;

    logic [AXIS_DATA_WIDTH-1:0] gen_tdata;
    logic [AXIS_KEEP_WIDTH-1:0] gen_tkeep;
    logic                       gen_tlast;

    mqnic_pause_frame_gen #(
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
        .AXIS_KEEP_WIDTH (AXIS_KEEP_WIDTH)
    ) u_pause_gen (
        .beat   (beat),
        .quanta (frame_quanta),
        .mac    (cfg_local_mac),
        .tdata  (gen_tdata),
        .tkeep  (gen_tkeep),
        .tlast  (gen_tlast)
    );

    assign tready_eff = (AXIS_USE_READY != 0) ? m_axis_tready : 1'b1;
    assign accept     = m_axis_tvalid && tready_eff;

    always_comb begin
        if (rx_pause_valid)
            timer_next = TIMER_W'(rx_pause_quanta) * TIMER_W'(PAUSE_QUANTUM_CYCLES);
        else if (timer != '0)
            timer_next = timer - TIMER_W'(1);
        else
            timer_next = timer;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = 1'b0;
        case (state)
            IDLE, DATA: begin
                if (state == DATA || (!pending && timer == '0)) begin
                    m_axis_tdata  = s_axis_tdata;
                    m_axis_tkeep  = s_axis_tkeep;
                    m_axis_tvalid = s_axis_tvalid;
                    m_axis_tlast  = s_axis_tlast;
                    m_axis_tuser  = s_axis_tuser;
                    s_axis_tready = tready_eff;
                end
            end
            PAUSE_TX: begin
                m_axis_tdata  = gen_tdata;
                m_axis_tkeep  = gen_tkeep;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = gen_tlast;
            end
            default: ;
        endcase
        // Reset drops the handshake at once; the MAC discards the truncated frame.
        if (rst) begin
            m_axis_tvalid = 1'b0;
            s_axis_tready = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            req_quanta   <= '0;
            frame_quanta <= '0;
            beat         <= '0;
            timer        <= '0;
            tx_paused    <= 1'b0;
        end else begin
            timer     <= timer_next;
            tx_paused <= (timer_next != '0);

            if (tx_pause_req) begin
                pending    <= 1'b1;
                req_quanta <= tx_pause_quanta;
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        // Quanta are frozen here; a request arriving from now on stays pending.
                        state        <= PAUSE_TX;
                        frame_quanta <= req_quanta;
                        beat         <= '0;
                        if (!tx_pause_req)
                            pending <= 1'b0;
                    end else if (accept && !s_axis_tlast) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (accept && s_axis_tlast)
                        state <= IDLE;
                end
                PAUSE_TX: begin
                    if (accept) begin
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                            beat  <= '0;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MQNIC_L2_EGRESS_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pause_tx_frames <= '0;
            stat_paused_cycles   <= '0;
        end else begin
            if (state == PAUSE_TX && accept && beat == LAST_BEAT)
                stat_pause_tx_frames <= stat_pause_tx_frames + 32'd1;
            if (timer != '0)
                stat_paused_cycles <= stat_paused_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mqnic_l2_egress_mac_ctrl.sv
// Directed self-checking bench for mqnic_l2_egress_mac_ctrl (256-bit stream, ready honoured, 2 cycles/quantum).
module tb_mqnic_l2_egress_mac_ctrl;

    localparam int DW = 256;
    localparam int KW = DW/8;
    localparam int UW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [UW-1:0] s_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
    logic          tx_pause_req;
    logic [15:0]   tx_pause_quanta;
    logic [47:0]   cfg_local_mac;
    logic          rx_pause_valid;
    logic [15:0]   rx_pause_quanta;
    logic          tx_paused;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] out_data[$];
    logic [KW-1:0] out_keep[$];
    logic          out_last[$];
    logic [UW-1:0] out_user[$];

    always #5 clk = ~clk;

    mqnic_l2_egress_mac_ctrl #(
        .AXIS_DATA_WIDTH      (DW),
        .AXIS_KEEP_WIDTH      (KW),
        .AXIS_USER_WIDTH      (UW),
        .AXIS_USE_READY       (1),
        .PAUSE_QUANTUM_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .tx_pause_req    (tx_pause_req),
        .tx_pause_quanta (tx_pause_quanta),
        .cfg_local_mac   (cfg_local_mac),
        .rx_pause_valid  (rx_pause_valid),
        .rx_pause_quanta (rx_pause_quanta),
        .tx_paused       (tx_paused)
    );

    // Inputs change on the falling edge; beats that will be accepted are logged mid-cycle.
    always @(negedge clk) begin
        #2;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            out_data.push_back(m_axis_tdata);
            out_keep.push_back(m_axis_tkeep);
            out_last.push_back(m_axis_tlast);
            out_user.push_back(m_axis_tuser);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        out_data.delete();
        out_keep.delete();
        out_last.delete();
        out_user.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int paused;
        int start;
        int seen;

        rst             = 1'b1;
        s_axis_tdata    = '0;
        s_axis_tkeep    = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        s_axis_tuser    = '0;
        m_axis_tready   = 1'b1;
        tx_pause_req    = 1'b0;
        tx_pause_quanta = '0;
        cfg_local_mac   = 48'h02_11_22_33_44_55;
        rx_pause_valid  = 1'b0;
        rx_pause_quanta = '0;

        // Reset state
        #1;
        check("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("rst_s_tready", DW'(s_axis_tready), DW'(0));
        check("rst_tx_paused", DW'(tx_paused), DW'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_s_tready", DW'(s_axis_tready), DW'(1));
        check("post_rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));

        // Back-to-back 3-beat frames, no bubbles
        clear_log();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {8{32'hA000_0000 + 32'(i)}};
            s_axis_tkeep  = '1;
            s_axis_tlast  = (i % 3 == 2);
            s_axis_tuser  = UW'(i % 2);
            #1;
            check("b2b_ready", DW'(s_axis_tready), DW'(1));
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #3;
        check("b2b_count", DW'(out_data.size()), DW'(6));
        for (int i = 0; i < 6; i++) begin
            check("b2b_data", out_data[i], {8{32'hA000_0000 + 32'(i)}});
            check("b2b_last", DW'(out_last[i]), DW'(i % 3 == 2));
            check("b2b_user", DW'(out_user[i]), DW'(i % 2));
        end

        // PAUSE request mid-frame: frame completes, then 2-beat PAUSE frame
        clear_log();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_axis_tvalid   = 1'b1;
            s_axis_tdata    = {8{32'hB000_0000 + 32'(i)}};
            s_axis_tkeep    = '1;
            s_axis_tlast    = (i == 3);
            s_axis_tuser    = '0;
            tx_pause_req    = (i == 1);
            tx_pause_quanta = 16'h1234;
            #1;
            check("midreq_ready", DW'(s_axis_tready), DW'(1));
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tx_pause_req  = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        check("midreq_count", DW'(out_data.size()), DW'(6));
        for (int i = 0; i < 4; i++)
            check("midreq_data", out_data[i], {8{32'hB000_0000 + 32'(i)}});
        check("pause_da", DW'(out_data[4][47:0]), DW'(48'h0100_00C2_8001));
        check("pause_sa", DW'(out_data[4][95:48]), DW'(48'h5544_3322_1102));
        check("pause_type_op_q", DW'(out_data[4][143:96]), DW'(48'h3412_0100_0888));
        check("pause_pad0", DW'(out_data[4][255:144]), DW'(0));
        check("pause_b0_keep", DW'(out_keep[4]), DW'(32'hFFFF_FFFF));
        check("pause_b0_last", DW'(out_last[4]), DW'(0));
        check("pause_b0_user", DW'(out_user[4]), DW'(0));
        check("pause_b1_data", out_data[5], DW'(0));
        check("pause_b1_keep", DW'(out_keep[5]), DW'(32'h0FFF_FFFF));
        check("pause_b1_last", DW'(out_last[5]), DW'(1));

        // Received PAUSE quanta 3 -> 6 paused cycles, held frame starts when timer hits 0
        clear_log();
        @(negedge clk);
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd3;
        @(negedge clk);
        rx_pause_valid = 1'b0;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = {8{32'hC0DE_0003}};
        s_axis_tlast   = 1'b1;
        paused = 0;
        start  = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (tx_paused) paused++;
            if (s_axis_tready) begin
                start = k;
                break;
            end
        end
        check("rxpause_paused_cycles", DW'(paused), DW'(6));
        check("rxpause_start_cycle", DW'(start), DW'(7));
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #3;
        check("rxpause_count", DW'(out_data.size()), DW'(1));
        check("rxpause_data", out_data[0], {8{32'hC0DE_0003}});

        // Quanta 100 then quanta 0 -> pause lifts on the next cycle
        clear_log();
        @(negedge clk);
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd100;
        @(negedge clk);
        rx_pause_valid = 1'b0;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = {8{32'hC0DE_0100}};
        s_axis_tlast   = 1'b1;
        repeat (8) @(negedge clk);
        @(negedge clk);
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd0;
        #1;
        check("xon_still_paused", DW'(tx_paused), DW'(1));
        check("xon_held_ready", DW'(s_axis_tready), DW'(0));
        @(negedge clk);
        rx_pause_valid = 1'b0;
        #1;
        check("xon_released", DW'(tx_paused), DW'(0));
        check("xon_resume_ready", DW'(s_axis_tready), DW'(1));
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #3;
        check("xon_count", DW'(out_data.size()), DW'(1));

        // Two requests during a frame collapse to one PAUSE frame; backpressure mid-frame
        clear_log();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_axis_tvalid   = 1'b1;
            s_axis_tdata    = {8{32'hD000_0000 + 32'(i)}};
            s_axis_tlast    = (i == 3);
            tx_pause_req    = (i == 0 || i == 2);
            tx_pause_quanta = (i == 0) ? 16'd5 : 16'd7;
        end
        for (int k = 4; k < 12; k++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            tx_pause_req  = 1'b0;
            m_axis_tready = (k != 6);
            #1;
            if (k == 6 || k == 7) begin
                check("bp_tvalid_held", DW'(m_axis_tvalid), DW'(1));
                check("bp_keep_held", DW'(m_axis_tkeep), DW'(32'h0FFF_FFFF));
                check("bp_last_held", DW'(m_axis_tlast), DW'(1));
            end
        end
        #3;
        check("bp_count", DW'(out_data.size()), DW'(6));
        check("bp_quanta", DW'(out_data[4][143:128]), DW'(16'h0700));
        check("bp_b0_last", DW'(out_last[4]), DW'(0));
        check("bp_b1_last", DW'(out_last[5]), DW'(1));

        // Reset in the middle of a PAUSE frame
        clear_log();
        m_axis_tready = 1'b1;
        @(negedge clk);
        tx_pause_req    = 1'b1;
        tx_pause_quanta = 16'h00AA;
        @(negedge clk);
        tx_pause_req = 1'b0;
        @(negedge clk);
        m_axis_tready = 1'b0;
        #1;
        check("rstmid_tvalid_before", DW'(m_axis_tvalid), DW'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_tvalid_async", DW'(m_axis_tvalid), DW'(0));
        check("rstmid_s_tready", DW'(s_axis_tready), DW'(0));
        repeat (2) @(negedge clk);
        rst           = 1'b0;
        m_axis_tready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (m_axis_tvalid) seen++;
        end
        check("rstmid_no_frame", DW'(seen), DW'(0));
        check("rstmid_log_empty", DW'(out_data.size()), DW'(0));
        check("rstmid_ready", DW'(s_axis_tready), DW'(1));

        // XON request (quanta 0) is still sent as a PAUSE frame
        clear_log();
        @(negedge clk);
        tx_pause_req    = 1'b1;
        tx_pause_quanta = 16'h0000;
        @(negedge clk);
        tx_pause_req = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        check("xonreq_count", DW'(out_data.size()), DW'(2));
        check("xonreq_hdr", DW'(out_data[0][143:96]), DW'(48'h0000_0100_0888));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
